change_dispense_ctrl: RTL and testbench

//  Sequences the coin-return hopper after a vend. Takes a change amount (nickel units) from the

---
 rtl/change_dispense_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_change_dispense_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// change_dispense_ctrl
//
// Coin-return hopper sequencer. After a vend, the vending core hands over the
// change owed (in nickels). The block greedily picks the largest stocked coin
// that still fits the amount owed and ejects it over a valid/ack handshake,
// one coin at a time, until the amount reaches zero (done pulse) or no stocked
// coin fits / the hopper stops acknowledging (fault).
//
// Ports
//   i_clk            system clock, all logic on the rising edge
//   i_reset          synchronous, active-high reset
//   i_change_req     start request, accepted only while o_change_ready=1
//   i_change_amt     change owed in nickels, sampled with an accepted request
//   i_bank           coin stock mask {FULLD,HALFD,QUARTER,DIME,NICKEL}, 1 = tube non-empty
//   i_eject_ack      hopper has ejected the coin shown on o_eject_coin
//   i_fault_clr      leaves FAULT and returns to IDLE
//   o_change_ready   high in IDLE only
//   o_eject_valid    eject request, high in EJECT only
//   o_eject_coin     one-hot coin to eject (same encoding as i_bank)
//   o_change_done    one-cycle pulse when the full amount has been dispensed
//   o_change_fault   high while in FAULT
//   o_remaining      nickels still owed
//   o_coins_out      coins ejected in the current/last transaction, saturates at 15
// -----------------------------------------------------------------------------
module change_dispense_ctrl #(
    parameter int AMT_W   = 6,
    parameter int TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_change_req,
    input  logic [AMT_W-1:0] i_change_amt,
    input  logic [4:0]       i_bank,
    input  logic             i_eject_ack,
    input  logic             i_fault_clr,
    output logic             o_change_ready,
    output logic             o_eject_valid,
    output logic [4:0]       o_eject_coin,
    output logic             o_change_done,
    output logic             o_change_fault,
    output logic [AMT_W-1:0] o_remaining,
    output logic [3:0]       o_coins_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_DONE,
        S_FAULT
    } state_t;

    // Coin bit positions in i_bank / o_eject_coin.
    localparam int B_NICKEL  = 0;
    localparam int B_DIME    = 1;
    localparam int B_QUARTER = 2;
    localparam int B_HALFD   = 3;
    localparam int B_FULLD   = 4;

    // Coin values in nickels.
    localparam logic [AMT_W-1:0] V_NICKEL  = AMT_W'(1);
    localparam logic [AMT_W-1:0] V_DIME    = AMT_W'(2);
    localparam logic [AMT_W-1:0] V_QUARTER = AMT_W'(5);
    localparam logic [AMT_W-1:0] V_HALFD   = AMT_W'(10);
    localparam logic [AMT_W-1:0] V_FULLD   = AMT_W'(20);

    localparam int               TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [AMT_W-1:0] r_remaining;
    logic [3:0]       r_coins;
    logic [4:0]       r_coin;
    logic [TMR_W-1:0] r_tmr;

    state_t           w_state_nxt;
    logic [AMT_W-1:0] w_remaining_nxt;
    logic [3:0]       w_coins_nxt;
    logic [4:0]       w_coin_nxt;
    logic [TMR_W-1:0] w_tmr_nxt;

    logic [4:0]       w_pick;
    logic [AMT_W-1:0] w_coin_val;
    logic [AMT_W-1:0] w_rem_after;

    // Greedy selection: the largest stocked coin not exceeding the amount owed.
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_pick = '0;
        if (i_bank[B_FULLD] && (r_remaining >= V_FULLD)) begin
            w_pick[B_FULLD] = 1'b1;
        end else if (i_bank[B_HALFD] && (r_remaining >= V_HALFD)) begin
            w_pick[B_HALFD] = 1'b1;
        end else if (i_bank[B_QUARTER] && (r_remaining >= V_QUARTER)) begin
            w_pick[B_QUARTER] = 1'b1;
        end else if (i_bank[B_DIME] && (r_remaining >= V_DIME)) begin
            w_pick[B_DIME] = 1'b1;
        end else if (i_bank[B_NICKEL] && (r_remaining >= V_NICKEL)) begin
            w_pick[B_NICKEL] = 1'b1;
        end
    end

    // Value of the coin currently offered to the hopper.
    always_comb begin
        w_coin_val = '0;
        case (r_coin)
            5'b00001: w_coin_val = V_NICKEL;
            5'b00010: w_coin_val = V_DIME;
            5'b00100: w_coin_val = V_QUARTER;
            5'b01000: w_coin_val = V_HALFD;
            5'b10000: w_coin_val = V_FULLD;
            default:  w_coin_val = '0;
        endcase
    end

    // Selection already guarantees value <= remaining; the clamp keeps the
    // amount from wrapping even if that invariant were ever broken.
    assign w_rem_after = (w_coin_val > r_remaining) ? '0 : (r_remaining - w_coin_val);

    // Next-state and next-register logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_coins_nxt     = r_coins;
        w_coin_nxt      = r_coin;
        w_tmr_nxt       = r_tmr;

        case (r_state)
            S_IDLE: begin
                if (i_change_req) begin
                    w_remaining_nxt = i_change_amt;
                    w_coins_nxt     = '0;
                    w_coin_nxt      = '0;
                    w_state_nxt     = (i_change_amt == '0) ? S_DONE : S_SELECT;
                end
            end

            S_SELECT: begin
                if (w_pick != '0) begin
                    w_coin_nxt  = w_pick;
                    w_tmr_nxt   = '0;
                    w_state_nxt = S_EJECT;
                end else begin
                    w_coin_nxt  = '0;
                    w_state_nxt = S_FAULT;
                end
            end

            S_EJECT: begin
                if (i_eject_ack) begin
                    w_remaining_nxt = w_rem_after;
                    w_coins_nxt     = (r_coins == 4'd15) ? r_coins : (r_coins + 4'd1);
                    if (w_rem_after == '0) begin
                        w_coin_nxt  = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_SELECT;
                    end
                end else if (r_tmr == TMR_LAST) begin
                    // Hopper stalled: give up, leaving the undispensed amount visible.
                    w_coin_nxt  = '0;
                    w_state_nxt = S_FAULT;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            S_FAULT: begin
                if (i_fault_clr) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_coins     <= '0;
            r_coin      <= '0;
            r_tmr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_coins     <= w_coins_nxt;
            r_coin      <= w_coin_nxt;
            r_tmr       <= w_tmr_nxt;
        end
    end

    // Moore outputs decoded from registered state.
    assign o_change_ready = (r_state == S_IDLE);
    assign o_eject_valid  = (r_state == S_EJECT);
    assign o_eject_coin   = r_coin;
    assign o_change_done  = (r_state == S_DONE);
    assign o_change_fault = (r_state == S_FAULT);
    assign o_remaining    = r_remaining;
    assign o_coins_out    = r_coins;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// tb_change_dispense_ctrl
//
// Bench for change_dispense_ctrl. A table of change transactions drives the
// request side while a small greedy coin model fills a scoreboard queue with
// the coins the hopper should see; each acknowledged eject pops that queue.
// Hand-written sequences cover requests during EJECT, ack outside EJECT and
// reset in the middle of an eject.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_change_dispense_ctrl;

    localparam int AMT_W   = 6;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 255;

    localparam logic [4:0] C_NICKEL  = 5'b00001;
    localparam logic [4:0] C_DIME    = 5'b00010;
    localparam logic [4:0] C_QUARTER = 5'b00100;

    logic             clk = 1'b0;
    logic             i_reset;
    logic             i_change_req;
    logic [AMT_W-1:0] i_change_amt;
    logic [4:0]       i_bank;
    logic             i_eject_ack;
    logic             i_fault_clr;
    logic             o_change_ready;
    logic             o_eject_valid;
    logic [4:0]       o_eject_coin;
    logic             o_change_done;
    logic             o_change_fault;
    logic [AMT_W-1:0] o_remaining;
    logic [3:0]       o_coins_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] exp_q[$];

    typedef struct {
        logic [AMT_W-1:0] amt;
        logic [4:0]       bank;
        int               ack_lat;    // valid cycles before ack is raised
        int               exp_coins;
        int               exp_rem;
        bit               exp_fault;
        int               exp_vcyc;   // total cycles with eject_valid high
    } vec_t;

    vec_t vecs[9];

    change_dispense_ctrl #(
        .AMT_W   (AMT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_change_req   (i_change_req),
        .i_change_amt   (i_change_amt),
        .i_bank         (i_bank),
        .i_eject_ack    (i_eject_ack),
        .i_fault_clr    (i_fault_clr),
        .o_change_ready (o_change_ready),
        .o_eject_valid  (o_eject_valid),
        .o_eject_coin   (o_eject_coin),
        .o_change_done  (o_change_done),
        .o_change_fault (o_change_fault),
        .o_remaining    (o_remaining),
        .o_coins_out    (o_coins_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and move to the sampling point just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Greedy reference: pushes the expected one-hot coin sequence.
    function automatic void push_greedy(input int amt, input logic [4:0] bank);
        int vals[5] = '{1, 2, 5, 10, 20};
        int rem = amt;
        bit found = 1'b1;
        while (found && rem > 0) begin
            found = 1'b0;
            for (int c = 4; c >= 0; c--) begin
                if (!found && bank[c] && vals[c] <= rem) begin
                    logic [4:0] oh = '0;
                    oh[c] = 1'b1;
                    exp_q.push_back(oh);
                    rem   = rem - vals[c];
                    found = 1'b1;
                end
            end
        end
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 0, vcyc = 0, lat_cnt = 0, first_valid = -1;
        bit seen_fault = 1'b0, finished = 1'b0;
        logic [4:0] popped;

        check($sformatf("v%0d_ready_before_req", idx), o_change_ready, 1);
        exp_q.delete();
        push_greedy(int'(v.amt), v.bank);
        i_change_amt = v.amt;
        i_bank       = v.bank;
        i_change_req = 1'b1;
        tick();
        i_change_req = 1'b0;
        cyc = 1;

        while (!finished && cyc < 300) begin
            if (o_eject_valid) begin
                if (first_valid < 0) first_valid = cyc;
                vcyc++;
                if (exp_q.size() == 0) begin
                    check($sformatf("v%0d_unexpected_eject", idx), o_eject_coin, 0);
                end else begin
                    check($sformatf("v%0d_eject_coin", idx), o_eject_coin, exp_q[0]);
                end
                if (lat_cnt >= v.ack_lat) begin
                    i_eject_ack = 1'b1;
                    if (exp_q.size() != 0) popped = exp_q.pop_front();
                    lat_cnt = 0;
                end else begin
                    i_eject_ack = 1'b0;
                    lat_cnt++;
                end
            end else begin
                i_eject_ack = 1'b0;
            end

            if (o_change_done) begin
                check($sformatf("v%0d_done_coins_out", idx), o_coins_out, v.exp_coins);
                check($sformatf("v%0d_done_remaining", idx), o_remaining, v.exp_rem);
                check($sformatf("v%0d_done_coin_zero", idx), o_eject_coin, 0);
                tick();
                cyc++;
                check($sformatf("v%0d_done_one_cycle", idx), o_change_done, 0);
                check($sformatf("v%0d_ready_after_done", idx), o_change_ready, 1);
                finished = 1'b1;
            end else if (o_change_fault) begin
                seen_fault = 1'b1;
                check($sformatf("v%0d_fault_valid_low", idx), o_eject_valid, 0);
                check($sformatf("v%0d_fault_remaining", idx), o_remaining, v.exp_rem);
                check($sformatf("v%0d_fault_coins_out", idx), o_coins_out, v.exp_coins);
                finished = 1'b1;
            end else begin
                tick();
                cyc++;
            end
        end
        i_eject_ack = 1'b0;

        check($sformatf("v%0d_terminated", idx), finished, 1);
        check($sformatf("v%0d_fault_flag", idx), seen_fault, v.exp_fault);
        check($sformatf("v%0d_valid_cycles", idx), vcyc, v.exp_vcyc);
        check($sformatf("v%0d_first_valid_edge", idx), first_valid, (v.exp_vcyc > 0) ? 2 : -1);

        if (seen_fault) begin
            tick();
            check($sformatf("v%0d_fault_sticky", idx), o_change_fault, 1);
            i_fault_clr = 1'b1;
            tick();
            i_fault_clr = 1'b0;
            check($sformatf("v%0d_ready_after_clr", idx), o_change_ready, 1);
            check($sformatf("v%0d_fault_cleared", idx), o_change_fault, 0);
            check($sformatf("v%0d_rem_kept_after_clr", idx), o_remaining, v.exp_rem);
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        //            amt  bank      lat    coins rem fault vcyc
        vecs[0] = '{6'd7,  5'b11111, 0,     2,    0,  0,    2};   // QUARTER, DIME
        vecs[1] = '{6'd7,  5'b11011, 0,     4,    0,  0,    4};   // D,D,D,N
        vecs[2] = '{6'd3,  5'b00100, 0,     0,    3,  1,    0};   // nothing fits
        vecs[3] = '{6'd4,  5'b11111, NEVER, 0,    4,  1,    16};  // hopper stall
        vecs[4] = '{6'd0,  5'b11111, 0,     0,    0,  0,    0};   // zero change
        vecs[5] = '{6'd13, 5'b11111, 2,     3,    0,  0,    9};   // HALFD,DIME,NICKEL slow ack
        vecs[6] = '{6'd63, 5'b11111, 0,     5,    0,  0,    5};   // max amount
        vecs[7] = '{6'd63, 5'b00001, 0,     15,   0,  0,    63};  // coins_out saturation
        vecs[8] = '{6'd7,  5'b00100, 1,     1,    2,  1,    2};   // bank gap after one coin

        i_reset      = 1'b1;
        i_change_req = 1'b0;
        i_change_amt = '0;
        i_bank       = '0;
        i_eject_ack  = 1'b0;
        i_fault_clr  = 1'b0;
        repeat (3) tick();
        i_reset = 1'b0;

        check("reset_ready",     o_change_ready, 1);
        check("reset_valid",     o_eject_valid, 0);
        check("reset_coin",      o_eject_coin, 0);
        check("reset_done",      o_change_done, 0);
        check("reset_fault",     o_change_fault, 0);
        check("reset_remaining", o_remaining, 0);
        check("reset_coins_out", o_coins_out, 0);

        // Ack while idle must not start anything.
        i_eject_ack = 1'b1;
        tick();
        i_eject_ack = 1'b0;
        check("idle_ack_ignored", o_change_ready, 1);

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
            tick();
        end

        // Request during EJECT is ignored; ack held high through SELECT is ignored.
        exp_q.delete();
        push_greedy(4, 5'b11111);
        i_change_amt = 6'd4;
        i_bank       = 5'b11111;
        i_change_req = 1'b1;
        tick();                                   // now SELECT
        i_change_amt = 6'd9;                      // request stays high with new amount
        check("seq_a_select_no_valid", o_eject_valid, 0);
        tick();                                   // now EJECT
        for (int k = 0; k < 3; k++) begin
            check("seq_a_valid_held", o_eject_valid, 1);
            check("seq_a_coin_held", o_eject_coin, exp_q[0]);
            check("seq_a_rem_unchanged", o_remaining, 4);
            check("seq_a_not_ready", o_change_ready, 0);
            tick();
        end
        i_change_req = 1'b0;
        check("seq_a_coin1", o_eject_coin, exp_q.pop_front());
        i_eject_ack = 1'b1;
        tick();                                   // SELECT, ack high but ignored here
        check("seq_a_rem_after_1", o_remaining, 2);
        check("seq_a_coins_after_1", o_coins_out, 1);
        check("seq_a_select_valid_low", o_eject_valid, 0);
        tick();                                   // EJECT second coin
        check("seq_a_coin2", o_eject_coin, exp_q.pop_front());
        tick();                                   // DONE
        i_eject_ack = 1'b0;
        check("seq_a_done", o_change_done, 1);
        check("seq_a_rem_done", o_remaining, 0);
        check("seq_a_coins_done", o_coins_out, 2);
        tick();
        check("seq_a_ready", o_change_ready, 1);

        // Reset while eject_valid is high.
        i_change_amt = 6'd20;
        i_bank       = C_NICKEL;
        i_change_req = 1'b1;
        tick();
        i_change_req = 1'b0;
        tick();
        check("seq_b_valid_before_reset", o_eject_valid, 1);
        check("seq_b_coin_before_reset", o_eject_coin, C_NICKEL);
        i_eject_ack = 1'b1;
        tick();
        i_eject_ack = 1'b0;
        tick();
        check("seq_b_rem_mid", o_remaining, 19);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("seq_b_ready",     o_change_ready, 1);
        check("seq_b_valid",     o_eject_valid, 0);
        check("seq_b_coin",      o_eject_coin, 0);
        check("seq_b_done",      o_change_done, 0);
        check("seq_b_fault",     o_change_fault, 0);
        check("seq_b_remaining", o_remaining, 0);
        check("seq_b_coins_out", o_coins_out, 0);

        run_vec(9, vecs[0]);

        // Single-coin check of the exact greedy encoding for a quarter + dime split.
        exp_q.delete();
        i_change_amt = 6'd7;
        i_bank       = 5'b11111;
        i_change_req = 1'b1;
        tick();
        i_change_req = 1'b0;
        tick();
        check("seq_c_first_quarter", o_eject_coin, C_QUARTER);
        i_eject_ack = 1'b1;
        tick();
        i_eject_ack = 1'b0;
        tick();
        check("seq_c_second_dime", o_eject_coin, C_DIME);
        i_eject_ack = 1'b1;
        tick();
        i_eject_ack = 1'b0;
        check("seq_c_done", o_change_done, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
